// File: rtl/battle_sequencer_if.sv
// Handshake bundle between the battle sequencer and the damage calculator.
// The sequencer owns calcStart; the calculator owns the result fields.
interface battle_sequencer_if;
  logic       calcStart;
  logic       calcComplete;
  logic [7:0] calcDamage;
  logic       calcHeal;

  modport master (
    output calcStart,
    input  calcComplete,
    input  calcDamage,
    input  calcHeal
  );

  modport slave (
    input  calcStart,
    output calcComplete,
    output calcDamage,
    output calcHeal
  );
endinterface

// File: rtl/battle_sequencer.sv
// Per-frame damage round sequencer: requests a calculation, applies damage/heal to HP.
// Optional feature: define INVINCIBILITY_EN to enable post-hit invincibility frames.
module battle_sequencer #(
  parameter int MAX_HP       = 100,
  parameter int HEAL_AMOUNT  = 5,
  parameter int CALC_TIMEOUT = 15,
  parameter int IFRAME_TICKS = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frameTick,
  input  logic                  newGame,
  battle_sequencer_if.master    calc,
  output logic [7:0]            hp,
  output logic                  hit,
  output logic                  gameOver,
  output logic                  busy,
  output logic [1:0]            errSticky
);

  localparam int CNT_W = $clog2(CALC_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_APPLY,
    S_OVER
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       hp_q, hp_d;
  logic             hit_q, hit_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       dmg_q, dmg_d;
  logic             heal_q, heal_d;

  logic [8:0]       eff_dmg9;
  logic [8:0]       inter9;
  logic [8:0]       healed9;
  logic [7:0]       result;

`ifdef INVINCIBILITY_EN
  localparam int IFR_W = $clog2(IFRAME_TICKS + 1);
  logic [IFR_W-1:0] ifr_q, ifr_d;
  logic             shield_q, shield_d;
`endif

  // Saturating subtract, then heal only if the player survived the hit.
  always_comb begin
`ifdef INVINCIBILITY_EN
    eff_dmg9 = shield_q ? 9'd0 : {1'b0, dmg_q};
`else
    eff_dmg9 = {1'b0, dmg_q};
`endif
    inter9  = (eff_dmg9 >= {1'b0, hp_q}) ? 9'd0 : ({1'b0, hp_q} - eff_dmg9);
    healed9 = inter9 + 9'(HEAL_AMOUNT);
    result  = inter9[7:0];
    if (heal_q && (inter9 != 9'd0)) begin
      result = (healed9 > 9'(MAX_HP)) ? 8'(MAX_HP) : healed9[7:0];
    end
  end

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    hit_d   = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    dmg_d   = dmg_q;
    heal_d  = heal_q;
`ifdef INVINCIBILITY_EN
    ifr_d    = ifr_q;
    shield_d = shield_q;
    if (frameTick && (ifr_q != '0)) begin
      ifr_d = ifr_q - IFR_W'(1);
    end
`endif

    unique case (state_q)
      S_IDLE: begin
        if (frameTick) begin
          state_d = S_START;
`ifdef INVINCIBILITY_EN
          // Shield status is decided by the frame that opens the round.
          shield_d = (ifr_q != '0);
`endif
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
        if (frameTick) err_d[1] = 1'b1;
      end
      S_WAIT: begin
        if (frameTick) err_d[1] = 1'b1;
        if (calc.calcComplete) begin
          dmg_d   = calc.calcDamage;
          heal_d  = calc.calcHeal;
          state_d = S_APPLY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == CNT_W'(CALC_TIMEOUT)) begin
            err_d[0] = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_APPLY: begin
        if (frameTick) err_d[1] = 1'b1;
        hp_d    = result;
        hit_d   = (eff_dmg9 != 9'd0);
        state_d = (result == 8'd0) ? S_OVER : S_IDLE;
`ifdef INVINCIBILITY_EN
        if (eff_dmg9 != 9'd0) ifr_d = IFR_W'(IFRAME_TICKS);
`endif
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (newGame) begin
      state_d = S_IDLE;
      hp_d    = 8'(MAX_HP);
      hit_d   = 1'b0;
      err_d   = 2'b00;
      cnt_d   = '0;
`ifdef INVINCIBILITY_EN
      ifr_d    = '0;
      shield_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hp_q    <= 8'(MAX_HP);
      hit_q   <= 1'b0;
      err_q   <= 2'b00;
      cnt_q   <= '0;
      dmg_q   <= 8'd0;
      heal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      dmg_q   <= dmg_d;
      heal_q  <= heal_d;
    end
  end

`ifdef INVINCIBILITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifr_q    <= '0;
      shield_q <= 1'b0;
    end else begin
      ifr_q    <= ifr_d;
      shield_q <= shield_d;
    end
  end
`endif

  assign calc.calcStart = (state_q == S_START);
  assign busy           = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_APPLY);
  assign gameOver       = (state_q == S_OVER);
  assign hp             = hp_q;
  assign hit            = hit_q;
  assign errSticky      = err_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// Randomized round-level bench for battle_sequencer with an HP/error reference model.
module tb_battle_sequencer;
  localparam int MAX_HP = 100;
  localparam int HEAL   = 5;
  localparam int TMO    = 15;
  localparam int IFR    = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frameTick = 1'b0;
  logic       newGame = 1'b0;
  logic [7:0] hp;
  logic       hit;
  logic       gameOver;
  logic       busy;
  logic [1:0] errSticky;

  battle_sequencer_if calc ();

  battle_sequencer #(
    .MAX_HP(MAX_HP),
    .HEAL_AMOUNT(HEAL),
    .CALC_TIMEOUT(TMO),
    .IFRAME_TICKS(IFR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frameTick(frameTick),
    .newGame(newGame),
    .calc(calc),
    .hp(hp),
    .hit(hit),
    .gameOver(gameOver),
    .busy(busy),
    .errSticky(errSticky)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_hp  = MAX_HP;
  int m_err = 0;
  bit m_over = 0;
  int m_ifr = 0;
  int round_no = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_frame();
`ifdef INVINCIBILITY_EN
    if (m_ifr > 0) m_ifr--;
`endif
  endfunction

  function automatic void model_new_game();
    m_hp = MAX_HP;
    m_err = 0;
    m_over = 0;
    m_ifr = 0;
  endfunction

  task automatic do_new_game();
    newGame = 1'b1;
    tick();
    newGame = 1'b0;
    model_new_game();
    check_eq("ng_hp", hp, m_hp);
    check_eq("ng_gameOver", gameOver, 0);
    check_eq("ng_err", errSticky, 0);
    check_eq("ng_busy", busy, 0);
    $display("newGame: hp=%0d", hp);
  endtask

  // One damage round: frameTick, calculator answers after lat cycles (lat>TMO means never),
  // optional overrun frameTick at busy cycle ovr, optional newGame alongside calcComplete.
  task automatic run_round(input int dmg, input bit heal, input int lat, input int ovr, input bit ng);
    bit shield;
    int eff, inter, exp_hp;
    int old_hp;
    shield = 0;
    round_no++;
`ifdef INVINCIBILITY_EN
    shield = (m_ifr > 0);
`endif
    old_hp = m_hp;
    frameTick = 1'b1;
    model_frame();
    tick();
    frameTick = 1'b0;

    if (m_over) begin
      for (int i = 0; i < 3; i++) begin
        check_eq("over_calcStart", calc.calcStart, 0);
        check_eq("over_busy", busy, 0);
        tick();
      end
      check_eq("over_gameOver", gameOver, 1);
      check_eq("over_err", errSticky, m_err);
      $display("round %0d: in OVER, frame ignored, hp=%0d", round_no, hp);
      return;
    end

    check_eq("calcStart", calc.calcStart, 1);
    check_eq("busy_start", busy, 1);

    if (lat > TMO) begin
      for (int i = 0; i < TMO; i++) begin
        if (i == ovr) begin
          frameTick = 1'b1;
          model_frame();
          m_err |= 2;
        end
        tick();
        frameTick = 1'b0;
      end
      check_eq("tmo_busy_last", busy, 1);
      tick();
      m_err |= 1;
      check_eq("tmo_busy", busy, 0);
      check_eq("tmo_err", errSticky, m_err);
      check_eq("tmo_hp", hp, m_hp);
      calc.calcComplete = 1'b1;
      calc.calcDamage = 8'd40;
      calc.calcHeal = 1'b0;
      tick();
      calc.calcComplete = 1'b0;
      tick();
      check_eq("late_done_hp", hp, m_hp);
      check_eq("late_done_hit", hit, 0);
      $display("round %0d: timeout, err=%0d hp=%0d", round_no, errSticky, hp);
      return;
    end

    for (int i = 0; i < lat; i++) begin
      if (i == ovr) begin
        frameTick = 1'b1;
        model_frame();
        m_err |= 2;
      end
      tick();
      frameTick = 1'b0;
    end
    calc.calcComplete = 1'b1;
    calc.calcDamage = 8'(dmg);
    calc.calcHeal = heal;
    if (ng) newGame = 1'b1;
    tick();
    calc.calcComplete = 1'b0;
    newGame = 1'b0;

    if (ng) begin
      model_new_game();
      check_eq("ngdone_busy", busy, 0);
      check_eq("ngdone_hp", hp, m_hp);
      check_eq("ngdone_err", errSticky, 0);
      tick();
      check_eq("ngdone_hit", hit, 0);
      check_eq("ngdone_hp2", hp, m_hp);
      $display("round %0d: newGame with calcComplete, hp=%0d", round_no, hp);
      return;
    end

    check_eq("apply_busy", busy, 1);
    check_eq("apply_hp_hold", hp, old_hp);
    tick();

    eff = shield ? 0 : dmg;
    inter = (eff >= m_hp) ? 0 : m_hp - eff;
    exp_hp = inter;
    if (heal && inter > 0) exp_hp = (inter + HEAL > MAX_HP) ? MAX_HP : inter + HEAL;
    m_hp = exp_hp;
    m_over = (exp_hp == 0);
`ifdef INVINCIBILITY_EN
    if (eff > 0) m_ifr = IFR;
`endif
    check_eq("hp", hp, m_hp);
    check_eq("hit", hit, (eff > 0) ? 1 : 0);
    check_eq("gameOver", gameOver, m_over ? 1 : 0);
    check_eq("busy_done", busy, 0);
    check_eq("err", errSticky, m_err);
    tick();
    check_eq("hit_one_pulse", hit, 0);
    $display("round %0d: dmg=%0d heal=%0d lat=%0d hp=%0d", round_no, dmg, heal, lat, hp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dmg, lat, ovr, lim;
    bit heal, ng;
    calc.calcComplete = 1'b0;
    calc.calcDamage = 8'd0;
    calc.calcHeal = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hp", hp, MAX_HP);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_calcStart", calc.calcStart, 0);
    check_eq("rst_gameOver", gameOver, 0);
    check_eq("rst_err", errSticky, 0);
    check_eq("rst_hit", hit, 0);
    rst_n = 1'b1;
    tick();

    // Basic hit, then HP cap and heal cases
    run_round(10, 0, 8, -1, 0);
    do_new_game();
    run_round(2, 0, 3, -1, 0);
    run_round(0, 1, 1, -1, 0);
    run_round(50, 0, 15, -1, 0);
    run_round(0, 1, 5, -1, 0);
    // Lethal hit with heal, frames ignored in OVER
    do_new_game();
    run_round(95, 0, 2, -1, 0);
    run_round(20, 1, 4, -1, 0);
    run_round(10, 0, 3, -1, 0);
    do_new_game();
    // Timeout with overrun, then reset mid-round
    run_round(0, 0, 20, 4, 0);
    run_round(7, 0, 6, -1, 0);

    frameTick = 1'b1;
    tick();
    frameTick = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_hp", hp, MAX_HP);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_calcStart", calc.calcStart, 0);
    check_eq("arst_err", errSticky, 0);
    check_eq("arst_gameOver", gameOver, 0);
    check_eq("arst_hit", hit, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_new_game();
    calc.calcComplete = 1'b1;
    calc.calcDamage = 8'd50;
    tick();
    calc.calcComplete = 1'b0;
    tick();
    check_eq("postrst_hp", hp, MAX_HP);
    check_eq("postrst_busy", busy, 0);
    check_eq("postrst_hit", hit, 0);
    $display("reset mid-round: hp=%0d busy=%0d", hp, busy);

    for (int r = 0; r < 250; r++) begin
      if (m_over && ($urandom_range(0, 2) == 0)) do_new_game();
      repeat ($urandom_range(0, 2)) tick();
      dmg = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 25));
      heal = 1'($urandom_range(0, 1));
      lat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 20)) : int'($urandom_range(1, 15));
      lim = (lat > TMO) ? TMO : lat;
      ovr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, lim - 1)) : -1;
      ng = ($urandom_range(0, 19) == 0);
      run_round(dmg, heal, lat, ovr, ng);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
